// File: rtl/mips_pkg.sv
// mips_pkg: shared fetch-stage defaults and the fetch queue entry type.
//   RESET_PC_DEF  : default PC fetched first after reset
//   IM_AW_DEF     : default instruction-memory word-address width
//   fetch_entry_t : {instr, pc} as buffered between fetch and decode
package mips_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int IM_AW_DEF = 7;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: 2-entry synchronous FIFO of fetch entries; flush beats push and pop.
//   clk, reset : clock and synchronous active-high reset
//   push, din  : enqueue din (ignored when full)
//   pop        : dequeue head (ignored when empty)
//   flush      : drop all entries
//   count      : number of stored entries, 0..2
//   head       : oldest entry
import mips_pkg::*;

module fetch_fifo (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    fetch_entry_t mem [2];
    logic rd_ptr, wr_ptr, do_push, do_pop;

    assign do_pop  = pop && count != 2'd0;
    assign do_push = push && count != 2'd2;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner and instruction fetch front end feeding decode.
//   clk, reset              : clock and synchronous active-high reset
//   redirect, redirect_addr : flush and restart fetch at redirect_addr (word aligned)
//   imem_addr, imem_data    : synchronous instruction memory, data one cycle after address
//   out_valid, out_ready    : valid/ready handshake towards decode
//   out_instr, out_pc, out_pc4 : head entry, its PC and PC+4 (zero while empty)
import mips_pkg::*;

module fetch_stage #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IM_AW    = IM_AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             redirect,
    input  logic [31:0]      redirect_addr,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [31:0]      imem_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_pc4
);
    logic [31:0]  pc, inflight_pc;
    logic         inflight, pop, push, issue;
    logic [1:0]   count;
    logic [2:0]   occupancy;
    fetch_entry_t head;

    assign pop       = out_valid && out_ready;
    assign push      = inflight && !redirect;
    // Credits: buffered entries plus the read in flight, minus the one leaving now.
    assign occupancy = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue     = !redirect && occupancy < 3'd2;
    assign imem_addr = reset ? RESET_PC[IM_AW+1:2] : pc[IM_AW+1:2];

    assign out_valid = count != 2'd0;
    assign out_instr = out_valid ? head.instr : '0;
    assign out_pc    = out_valid ? head.pc : '0;
    assign out_pc4   = out_valid ? head.pc + 32'd4 : '0;

    fetch_fifo u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   ('{instr: imem_data, pc: inflight_pc}),
        .count (count),
        .head  (head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect) begin
            pc       <= redirect_addr & ~32'h3;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset) push |-> count != 2'd2);
endmodule
